rr_decoder_arbiter: RTL and testbench

//   4-way round-robin arbiter that shares one resource between four requesters.
//   The winning index is registered and then driven through 2-to-4 decode onto a
//   one-hot grant bus.
//   A hold counter bounds how long one requester may keep the grant, which

---
 rtl/rr_decoder_arbiter.sv | 103 ++++++++++
 tb/tb_rr_decoder_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rr_decoder_arbiter.sv
// Four-way round-robin arbiter with a bounded hold time and one dead cycle per handover.
// The winning index is registered and decoded onto a one-hot grant bus.
module rr_decoder_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       expired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_r, next_state_s;
  logic [1:0]       ptr_r, ptr_nxt_s;
  logic [CNT_W-1:0] hold_cnt_r, hold_nxt_s;
  logic [1:0]       idx_nxt_s;
  logic [1:0]       winner_s;
  logic             expired_nxt_s;

  // Scan ptr, ptr+1, ptr+2, ptr+3 (2-bit wrap); the lowest offset with a set bit wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] pick;
    logic [1:0] cand;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      cand = p + 2'(k);
      pick = r[cand] ? cand : pick;
    end
    return pick;
  endfunction

  function automatic logic [3:0] decode2to4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  assign winner_s = rr_pick(req, ptr_r);

  // Next-state, pointer, hold counter and timeout decisions.
  always_comb begin
    next_state_s  = state_r;
    ptr_nxt_s     = ptr_r;
    hold_nxt_s    = hold_cnt_r;
    idx_nxt_s     = grant_idx;
    expired_nxt_s = 1'b0;
    case (state_r)
      IDLE, GAP: begin
        if (req != 4'b0000) begin
          next_state_s = GRANT;
          idx_nxt_s    = winner_s;
          hold_nxt_s   = {CNT_W{1'b0}};
        end else begin
          next_state_s = IDLE;
        end
      end
      GRANT: begin
        if (!req[grant_idx]) begin
          next_state_s = GAP;
          ptr_nxt_s    = grant_idx + 2'd1;
        end else if (hold_cnt_r == CNT_W'(MAX_HOLD - 1)) begin
          next_state_s  = GAP;
          ptr_nxt_s     = grant_idx + 2'd1;
          expired_nxt_s = 1'b1;
        end else begin
          hold_nxt_s = hold_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; grant is decoded from the index about to be held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= 2'd0;
      hold_cnt_r  <= {CNT_W{1'b0}};
      grant_idx   <= 2'd0;
      grant_valid <= 1'b0;
      grant       <= 4'b0000;
      expired     <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      ptr_r       <= ptr_nxt_s;
      hold_cnt_r  <= hold_nxt_s;
      grant_idx   <= idx_nxt_s;
      grant_valid <= (next_state_s == GRANT);
      grant       <= (next_state_s == GRANT) ? decode2to4(idx_nxt_s) : 4'b0000;
      expired     <= expired_nxt_s;
    end
  end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter: reset, single request, full rotation with
// timeouts, release before timeout, pointer wrap and asynchronous mid-grant reset.
module tb_rr_decoder_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       expired;

  int num_checks;
  int num_errors;
  bit running;

  rr_decoder_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .expired     (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Structural invariants on the grant bus, sampled on the falling edge.
  always @(negedge clk) begin
    if (running) begin
      check_value("onehot0", 32'($onehot0(grant)), 32'd1);
      check_value("valid_vs_grant", 32'(grant != 4'b0000), 32'(grant_valid));
    end
  end

  initial begin
    num_checks = 0;
    num_errors = 0;
    running    = 1'b0;
    rst        = 1'b1;
    req        = 4'b1111;

    // Reset held with all requests asserted
    tick();
    tick();
    running = 1'b1;
    check_value("rst_grant", 32'(grant), 32'h0);
    check_value("rst_valid", 32'(grant_valid), 32'h0);
    check_value("rst_expired", 32'(expired), 32'h0);
    check_value("rst_idx", 32'(grant_idx), 32'h0);
    req = 4'b0000;
    rst = 1'b0;
    tick();

    // Single request
    req = 4'b0100;
    tick();
    check_value("single_grant", 32'(grant), 32'h4);
    check_value("single_idx", 32'(grant_idx), 32'd2);
    check_value("single_valid", 32'(grant_valid), 32'd1);
    req = 4'b0000;
    tick();
    check_value("single_gap", 32'(grant), 32'h0);
    check_value("single_gap_exp", 32'(expired), 32'h0);
    tick();
    check_value("single_idle_valid", 32'(grant_valid), 32'h0);
    check_value("single_idle_idx", 32'(grant_idx), 32'd2);

    // All requesting and held: rotation with timeouts
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 8; c++) begin
        tick();
        check_value($sformatf("rot%0d_grant_c%0d", g, c), 32'(grant), 32'(4'b0001 << (g % 4)));
        check_value($sformatf("rot%0d_exp_c%0d", g, c), 32'(expired), 32'h0);
      end
      tick();
      check_value($sformatf("rot%0d_gap", g), 32'(grant), 32'h0);
      check_value($sformatf("rot%0d_expired", g), 32'(expired), 32'h1);
    end
    req = 4'b0000;
    tick();
    check_value("rot_idle", 32'(grant_valid), 32'h0);

    // Release beats timeout
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_value($sformatf("rel_g0_c%0d", c), 32'(grant), 32'h1);
    end
    req = 4'b0010;
    tick();
    check_value("rel_gap", 32'(grant), 32'h0);
    check_value("rel_gap_exp", 32'(expired), 32'h0);
    tick();
    check_value("rel_g1", 32'(grant), 32'h2);
    check_value("rel_g1_exp", 32'(expired), 32'h0);
    req = 4'b0000;
    tick();
    tick();

    // Wrap: owner 3 releases, pointer wraps to 0 so 0 beats 2
    req = 4'b1000;
    tick();
    check_value("wrap_g3", 32'(grant), 32'h8);
    req = 4'b1001;
    tick();
    check_value("wrap_g3_hold", 32'(grant), 32'h8);
    req = 4'b0101;
    tick();
    check_value("wrap_gap", 32'(grant), 32'h0);
    tick();
    check_value("wrap_g0", 32'(grant), 32'h1);
    check_value("wrap_idx", 32'(grant_idx), 32'd0);
    req = 4'b0000;
    tick();
    tick();

    // Mid-grant asynchronous reset
    req = 4'b1000;
    tick();
    check_value("mid_g3", 32'(grant), 32'h8);
    #2;
    rst = 1'b1;
    #1;
    check_value("mid_rst_grant", 32'(grant), 32'h0);
    check_value("mid_rst_idx", 32'(grant_idx), 32'd0);
    rst = 1'b0;
    req = 4'b1010;
    tick();
    check_value("mid_after_grant", 32'(grant), 32'h2);
    check_value("mid_after_idx", 32'(grant_idx), 32'd1);

    req = 4'b0000;
    tick();
    tick();
    running = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
